// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage boundary registers.
//   - state encoding for the stage occupancy FSM (EMPTY / HALF / FULL)
//   - ID/EX control-word field layout (offsets, widths, packed struct view)
//   - payload field indices for the packed 8 x 32-bit data word
//   - helper functions to turn a state into an entry count and a payload
//     field index into a bit offset
// -----------------------------------------------------------------------------
package pipe_pkg;

    // The state value is chosen so that it reads directly as the number of
    // held entries, which keeps the occupancy output trivial.
    typedef logic [1:0] pipe_state_t;

    localparam pipe_state_t PS_EMPTY = 2'd0;
    localparam pipe_state_t PS_HALF  = 2'd1;
    localparam pipe_state_t PS_FULL  = 2'd2;

    // ID/EX control-word field positions (LSB offset and width).
    localparam int IDEX_REGDST_LSB   = 0;
    localparam int IDEX_REGDST_W     = 2;
    localparam int IDEX_ALUSRCA_LSB  = 2;
    localparam int IDEX_ALUSRCB_LSB  = 3;
    localparam int IDEX_ALUOP_LSB    = 4;
    localparam int IDEX_ALUOP_W      = 3;
    localparam int IDEX_BEOP_LSB     = 7;
    localparam int IDEX_BEOP_W       = 3;
    localparam int IDEX_MEMREAD_LSB  = 10;
    localparam int IDEX_MEMWRITE_LSB = 11;
    localparam int IDEX_MEMTOREG_LSB = 12;
    localparam int IDEX_MEMTOREG_W   = 2;
    localparam int IDEX_REGWRITE_LSB = 14;
    localparam int IDEX_FIRST_LSB    = 15;
    localparam int IDEX_CTRL_W       = 16;

    // Packed view of the same ID/EX control word, MSB first.
    typedef struct packed {
        logic       first;
        logic       regwrite;
        logic [1:0] memtoreg;
        logic       memwrite;
        logic       memread;
        logic [2:0] beop;
        logic [2:0] aluop;
        logic       alusrcb;
        logic       alusrca;
        logic [1:0] regdst;
    } idex_ctrl_t;

    // Payload fields, each one 32-bit word of the packed data bus.
    localparam int PAYLOAD_FIELD_W = 32;

    typedef enum int {
        PF_NPC = 0,
        PF_BA  = 1,
        PF_A   = 2,
        PF_B   = 3,
        PF_EXT = 4,
        PF_IR  = 5,
        PF_CD  = 6
    } payload_field_e;

    // Bit offset of a payload field inside the packed data bus.
    function automatic int payload_lsb(input payload_field_e field);
        return int'(field) * PAYLOAD_FIELD_W;
    endfunction

    // Number of entries held in a given state.
    function automatic logic [1:0] state_count(input pipe_state_t state);
        logic [1:0] count;
        case (state)
            PS_HALF: count = 2'd1;
            PS_FULL: count = 2'd2;
            default: count = 2'd0;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// -----------------------------------------------------------------------------
// pipe_entry
// One storage slot of a pipeline stage: a valid bit, a control word and a
// data payload.
//   clk, rst_n  : clock, asynchronous active-low reset (clears everything)
//   load        : capture in_ctrl/in_data and mark the slot valid
//   clear       : invalidate the slot and zero the control word; the data
//                 payload is deliberately kept (it is don't-care once invalid)
//   in_ctrl     : control word to capture
//   in_data     : payload to capture
//   valid       : slot holds an entry
//   ctrl        : held control word
//   data        : held payload
// clear wins over load so a flush can never be overridden by a new entry.
// -----------------------------------------------------------------------------
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Slot register. Reset zeroes all fields so the stage comes up with a
    // clean, all-zero payload; clear only touches valid and ctrl so that the
    // wide data register does not need a clear path in normal operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Handshaked pipeline stage register used at every stage boundary
// (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control word and a packed payload
// with valid/ready flow control, optional two-entry skid buffer, synchronous
// flush with NOP insertion and a saturating kill counter.
//
// Parameters:
//   CTRL_W : control-word width
//   DATA_W : payload width
//   SKID   : 1 = main + skid entry, registered in_ready
//            0 = single entry, in_ready = !out_valid | out_ready
//   CNT_W  : kill-counter width
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : upstream entry valid
//   in_ready   : stage can accept this cycle
//   in_ctrl    : upstream control word
//   in_data    : upstream payload
//   flush      : drop all held entries and the current input
//   out_valid  : head entry valid
//   out_ready  : downstream accepts the head entry
//   out_ctrl   : head control word, zero (NOP) while out_valid is low
//   out_data   : head payload, keeps its last value while invalid
//   occupancy  : number of held entries (0..2)
//   kill_cnt   : saturating count of flush cycles that discarded something
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 256,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  kill_cnt
);

    localparam bit               HAS_SKID = (SKID != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_t       state;
    pipe_state_t       next_state;
    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic              kill_event;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;

    // Next-state and slot-control decode. Flush overrides every transition:
    // both slots are invalidated and the input of the flush cycle is never
    // loaded. Otherwise the stage behaves as a two-deep FIFO where the main
    // slot is always the head and the skid slot only ever holds the entry
    // that arrived while the head was stalled.
    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (flush) begin
            next_state = PS_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (in_fire) begin
                        next_state = PS_HALF;
                        main_load  = 1'b1;
                    end
                end
                PS_HALF: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && HAS_SKID) begin
                        next_state = PS_FULL;
                        skid_load  = 1'b1;
                    end else if (out_fire) begin
                        next_state = PS_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                PS_FULL: begin
                    if (out_fire && skid_valid) begin
                        next_state     = PS_HALF;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    next_state = PS_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // The head slot is refilled either from the upstream input or, when the
    // stage drains out of FULL, from the skid slot so ordering is preserved.
    always_comb begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
        if (main_from_skid) begin
            main_ctrl_d = skid_ctrl;
            main_data_d = skid_data;
        end
    end

    // State register. Its encoding doubles as the entry count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PS_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .clear   (main_clear),
        .in_ctrl (main_ctrl_d),
        .in_data (main_data_d),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    generate
        if (HAS_SKID) begin : g_skid
            logic in_ready_q;

            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (skid_load),
                .clear   (skid_clear),
                .in_ctrl (in_ctrl),
                .in_data (in_data),
                .valid   (skid_valid),
                .ctrl    (skid_ctrl),
                .data    (skid_data)
            );

            // Registered ready: computed from the next state so the upstream
            // never sees a combinational path from out_ready. It comes out of
            // reset high because the stage is empty.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (next_state != PS_FULL);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;

            // Single slot: accept when empty or when the head leaves this
            // same cycle, which still gives one entry per cycle throughput.
            assign in_ready = !main_valid || out_ready;
        end
    endgenerate

    // A flush only counts as a kill if it actually threw something away:
    // a held entry or an input being offered in the flush cycle.
    assign kill_event = flush && ((state != PS_EMPTY) || in_valid);

    // Saturating kill counter, only cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_cnt <= '0;
        end else if (kill_event && (kill_cnt != CNT_MAX)) begin
            kill_cnt <= kill_cnt + CNT_ONE;
        end
    end

    // Downstream sees a NOP control word whenever the stage is empty, so a
    // stall bubble needs no extra decode in the next stage.
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state_count(state);

endmodule
